// File: rtl/countdown_timer.sv
// Loadable down-counter: decrements once every PRESCALE clocks, pulses `expired`
// on reaching zero, with pause and optional auto-reload for periodic ticks.
module countdown_timer #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             pause,
  input  logic             auto_reload,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic             expired
);

  localparam int            PW      = $clog2(PRESCALE) + 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] count_n;
  logic [WIDTH-1:0] reload_reg, reload_n;
  logic [PW-1:0]    prescaler, prescaler_n;
  logic             expired_n;
  logic             active;
  logic             advance;
  logic             tick;

  // A HOLD timer whose pause has dropped advances on that same edge, so the
  // freeze lasts exactly as many cycles as pause is high.
  assign active  = (state != IDLE);
  assign advance = active && !start && !pause;
  assign tick    = advance && (prescaler == PS_LAST);
  assign busy    = active;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_n     = state;
    count_n     = count;
    reload_n    = reload_reg;
    prescaler_n = prescaler;
    expired_n   = 1'b0;

    if (start) begin
      count_n     = load_val;
      reload_n    = load_val;
      prescaler_n = '0;
      if (load_val != '0) begin
        state_n = RUN;
      end else begin
        state_n   = IDLE;
        expired_n = 1'b1;
      end
    end else if (active && pause) begin
      state_n = HOLD;
    end else if (advance) begin
      state_n = RUN;
      if (tick) begin
        prescaler_n = '0;
        if (count > WIDTH'(1)) begin
          count_n = count - WIDTH'(1);
        end else begin
          // Reaching zero; count == 0 in RUN cannot occur but is handled the same.
          expired_n = (count == WIDTH'(1));
          if (auto_reload && (count == WIDTH'(1))) begin
            count_n = reload_reg;
          end else begin
            count_n = '0;
            state_n = IDLE;
          end
        end
      end else begin
        prescaler_n = prescaler + PW'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      prescaler  <= '0;
      expired    <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      reload_reg <= reload_n;
      prescaler  <= prescaler_n;
      expired    <= expired_n;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench: two timers (PRESCALE 1 and 3) share one stimulus and are
// compared every cycle against an elapsed-time model, plus directed scenarios.
module tb_countdown_timer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] load_val;
  logic         pause;
  logic         auto_reload;
  logic         busy1, exp1, busy3, exp3;
  logic [W-1:0] count1, count3;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(W), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .load_val(load_val), .pause(pause),
    .auto_reload(auto_reload), .busy(busy1), .count(count1), .expired(exp1)
  );

  countdown_timer #(.WIDTH(W), .PRESCALE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .load_val(load_val), .pause(pause),
    .auto_reload(auto_reload), .busy(busy3), .count(count3), .expired(exp3)
  );

  // Model: a running timer of length L has advanced `elapsed` unpaused cycles;
  // remaining count is L - elapsed/P and expiry happens at elapsed == L*P.
  int m_p[2] = '{1, 3};
  bit m_run[2];
  int m_len[2];
  int m_elapsed[2];
  bit m_exp[2];

  function automatic int model_count(int k);
    return m_run[k] ? (m_len[k] - m_elapsed[k] / m_p[k]) : 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_len[k] = 0; m_elapsed[k] = 0; m_exp[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      m_exp[k] = 0;
      if (start) begin
        m_len[k]     = int'(load_val);
        m_elapsed[k] = 0;
        m_run[k]     = (load_val != 0);
        m_exp[k]     = (load_val == 0);
      end else if (m_run[k] && !pause) begin
        m_elapsed[k]++;
        if (m_elapsed[k] == m_len[k] * m_p[k]) begin
          m_exp[k]     = 1;
          m_elapsed[k] = 0;
          if (!auto_reload) m_run[k] = 0;
        end
      end
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, " count1"},  32'(count1), 32'(model_count(0)));
    check({tag, " busy1"},   32'(busy1),  32'(m_run[0]));
    check({tag, " exp1"},    32'(exp1),   32'(m_exp[0]));
    check({tag, " count3"},  32'(count3), 32'(model_count(1)));
    check({tag, " busy3"},   32'(busy3),  32'(m_run[1]));
    check({tag, " exp3"},    32'(exp3),   32'(m_exp[1]));
  endtask

  task automatic step(string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  // Asserts rst mid-cycle and checks the outputs before any clock edge.
  task automatic async_reset(string tag);
    rst = 1'b1;
    #2;
    model_reset();
    check_all(tag);
    #2 rst = 1'b0;
  endtask

  initial begin
    int n;
    logic [W-1:0] seq_auto [3];

    rst = 1'b1; start = 1'b0; load_val = '0; pause = 1'b0; auto_reload = 1'b0;
    #2;
    model_reset();
    check_all("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    check_all("post_reset");

    // PRESCALE=1, load 4: 4,3,2,1,0 with expired and busy-drop on the 4th edge
    start = 1'b1; load_val = 8'd4;
    step("load4");
    start = 1'b0;
    check("load4 first", 32'(count1), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      step("load4 run");
      check("load4 seq",  32'(count1), 32'(4 - i));
      check("load4 exp",  32'(exp1),   32'(i == 4));
      check("load4 busy", 32'(busy1),  32'(i != 4));
    end

    // Reset mid-run with count at 5 aborts without a clock edge
    start = 1'b1; load_val = 8'd9;
    step("load9");
    start = 1'b0;
    repeat (4) step("load9 run");
    check("pre_rst count", 32'(count1), 32'd5);
    async_reset("mid_rst");
    check("mid_rst count", 32'(count1), 32'd0);
    check("mid_rst busy",  32'(busy1),  32'd0);
    check("mid_rst exp",   32'(exp1),   32'd0);

    // PRESCALE=3, load 2: expiry 6 edges after the start edge
    start = 1'b1; load_val = 8'd2;
    step("p3 load2");
    start = 1'b0;
    n = 0;
    do begin
      step("p3 run");
      n++;
    end while (!exp3 && n < 30);
    check("p3 latency", 32'(n), 32'd6);

    // Pause for 5 cycles extends the PRESCALE=1 latency from 4 to 9
    start = 1'b1; load_val = 8'd4;
    step("pause load4");
    start = 1'b0;
    step("pause run");
    n = 1;
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step("paused");
      n++;
      check("paused count", 32'(count1), 32'd3);
      check("paused busy",  32'(busy1),  32'd1);
    end
    pause = 1'b0;
    do begin
      step("resume");
      n++;
    end while (!exp1 && n < 40);
    check("pause latency", 32'(n), 32'd9);

    // Auto-reload: 3,2,1,3,2,1 with an expiry every 3 cycles
    seq_auto[0] = 8'd2; seq_auto[1] = 8'd1; seq_auto[2] = 8'd3;
    auto_reload = 1'b1;
    start = 1'b1; load_val = 8'd3;
    step("auto load3");
    start = 1'b0;
    check("auto first", 32'(count1), 32'd3);
    for (int i = 0; i < 9; i++) begin
      step("auto run");
      check("auto seq", 32'(count1), 32'(seq_auto[i % 3]));
      check("auto exp", 32'(exp1),   32'((i % 3) == 2));
    end
    auto_reload = 1'b0;
    n = 0;
    do begin
      step("auto stop");
      n++;
    end while (!exp1 && n < 10);
    check("auto stop cycles", 32'(n), 32'd3);
    check("auto stop count",  32'(count1), 32'd0);
    check("auto stop busy",   32'(busy1),  32'd0);

    // Zero-length timer: expired on the next cycle, busy never set
    repeat (12) step("drain");
    start = 1'b1; load_val = 8'd0;
    step("zero load");
    start = 1'b0;
    check("zero exp",  32'(exp1),  32'd1);
    check("zero busy", 32'(busy1), 32'd0);
    step("zero after");
    check("zero exp off",  32'(exp1),  32'd0);
    check("zero busy off", 32'(busy1), 32'd0);

    // Restart mid-run: count=7 next edge and the prescaler restarts from 0
    start = 1'b1; load_val = 8'd20;
    step("restart load20");
    start = 1'b0;
    step("restart run");
    step("restart run");
    start = 1'b1; load_val = 8'd7;
    step("restart load7");
    start = 1'b0;
    load_val = 8'd55;
    check("restart count1", 32'(count1), 32'd7);
    check("restart count3", 32'(count3), 32'd7);
    step("restart p");
    step("restart p");
    check("restart hold3", 32'(count3), 32'd7);
    step("restart p");
    check("restart dec3", 32'(count3), 32'd6);

    // Randomized traffic with occasional async resets
    for (int c = 0; c < 600; c++) begin
      start       = ($urandom_range(0, 11) == 0);
      load_val    = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom_range(1, 12));
      pause       = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 19) == 0) auto_reload = ~auto_reload;
      step("rand");
      if ($urandom_range(0, 149) == 0) async_reset("rand_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter: the counterpart to the free-running modulo up-counter.
- Software or an FSM loads a count. The block decrements it once every PRESCALE clocks and pulses `expired` when it reaches zero.
- Supports pause and auto-reload, so the same block serves as a one-shot delay or a periodic tick generator.
- Sits beside the cycle counters in the CPU control path.

Parameters:
- WIDTH, 8, bit width of load value and count.
- PRESCALE, 1, clock cycles per decrement. Legal values are >= 1. The prescaler register is $clog2(PRESCALE)+1 bits wide.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  load load_val and begin counting. Sampled on posedge.
- load_val  input  WIDTH  initial and reload count value.
- pause  input  1  freezes count and prescaler while high.
- auto_reload  input  1  reload on expiry instead of stopping. Sampled on the expiry cycle.
- busy  output  1  high while state is RUN or HOLD.
- count  output  WIDTH  current remaining count (registered).
- expired  output  1  one-cycle pulse when count reaches 0.

Behaviour:
- Reset (rst high, asynchronous):
  - state=IDLE; count=0; reload_reg=0; prescaler=0; busy=0; expired=0.
  - Reset asserted mid-count aborts immediately. No expired pulse is issued.
- States: IDLE, RUN, HOLD. busy = (state != IDLE), decoded from the state register.
- tick = (prescaler == PRESCALE-1) while in RUN. On tick, prescaler returns to 0; otherwise it increments.
- Priority per cycle: start > pause > tick.
- start (any state):
  - count <= load_val; reload_reg <= load_val; prescaler <= 0.
  - If load_val != 0: next state RUN.
  - If load_val == 0: next state IDLE and expired=1 on the next cycle (zero-length timer).
- RUN:
  - pause=1 → HOLD; count and prescaler hold.
  - tick with count > 1 → count <= count-1.
  - tick with count == 1:
    - count <= 0 and expired <= 1.
    - If auto_reload=1: count <= reload_reg, prescaler 0, stay RUN.
    - Otherwise: → IDLE.
- HOLD:
  - pause=0 → RUN, resuming with the same count and prescaler values.
  - start in HOLD restarts per the start rule.
- IDLE: with no start, count holds its last value (0 after expiry). tick is ignored.
- expired:
  - Registered; high exactly one cycle per expiry.
  - With auto_reload and count reaching 1 again, pulses are spaced L*PRESCALE cycles apart.
- Latency: with start sampled at edge t and load_val=L (L>0), expired is high in the cycle after edge t + L*PRESCALE.
- count never wraps below 0. Decrement only happens when count >= 1.
- A mid-count change to load_val has no effect until the next start.

Test Plan:
- rst pulse mid-RUN (count=5) → count=0, busy=0, expired=0 immediately, without waiting for a clk edge.
- PRESCALE=1, start with load_val=4 → count 4,3,2,1,0 on successive edges; expired high only in the 4th cycle after start; busy falls in the same cycle.
- PRESCALE=3, load_val=2 → count decrements every 3 cycles; expired exactly 6 cycles after start.
- pause high for 5 cycles during RUN → count frozen for 5 cycles; total latency extended by 5; releasing pause resumes with no lost or extra tick.
- auto_reload=1, load_val=3, PRESCALE=1 → expired pulses every 3 cycles; count sequence 3,2,1,3,2,1…; clear auto_reload → stops after the next expiry with count=0.
- start with load_val=0 → expired one cycle later, busy never high. start asserted again mid-RUN with load_val=7 → count=7 and prescaler=0 on the next edge.
